mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates one shared, word-wide memory port between the instruction-fetch requester and the load/store requester of the MIPS core. This is the step from split i_mem/d_mem arrays to a single unified memory.
- Handles one outstanding transaction at a time. A fixed priority favours data, bounded by an anti-starvation counter for fetch.
- Registers each response back to the owning requester and flags misaligned word accesses without touching memory.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width. Fixed at 32; byte enables are not supported.
- STARVE_MAX, 4, number of consecutive data grants while fetch is waiting after which fetch is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held until granted.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch response valid; one-cycle pulse.
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request; held until granted.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response valid (load data or store ack); one-cycle pulse.
- d_rdata  out  DATA_W  load data; 0 for stores.
- err  out  1  misaligned access; qualifies the rvalid pulse in the same cycle.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word-aligned byte address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high when state is ISSUE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE, starve_cnt = 0.
  - All outputs are 0, including mem_req, which drops immediately.
  - Any in-flight transaction is discarded and no response is produced for it.
- FSM, two states:
  - IDLE: accepts a new request.
  - ISSUE: drives memory and waits for mem_ack.
- Grant in IDLE:
  - if_gnt and d_gnt are combinational from the requests, starve_cnt and state. They are never both 1 and are always 0 outside IDLE.
  - Only d_req: data wins.
  - Only if_req: fetch wins.
  - Both requesting: data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
- Accept (gnt=1):
  - Latch owner, addr, we and wdata into internal registers.
  - A fetch grant always latches we=0.
- Aligned accept (addr[1:0] == 0):
  - Go to ISSUE.
  - mem_req rises in the next cycle, with mem_we/mem_addr/mem_wdata driven from the latched fields and held stable until ack.
- Misaligned accept (addr[1:0] != 0):
  - Stay in IDLE; no mem_req.
  - Next cycle: owner's rvalid = 1, err = 1, rdata = 0.
- In ISSUE, on mem_ack = 1:
  - mem_req is still high during the ack cycle and is 0 in the following cycle.
  - State returns to IDLE.
  - Next cycle: owner's rvalid = 1, rdata = mem_rdata captured at ack (0 if we = 1), err = 0.
- In ISSUE, mem_ack = 0: hold all memory outputs; no timeout.
- Responses are registered: exactly one rvalid pulse per grant, in grant order. The non-owner's rvalid stays 0.
- Throughput:
  - One transaction per 2 cycles minimum (accept cycle + ack cycle, zero-wait memory).
  - A new accept may coincide with the previous rvalid pulse.
- starve_cnt update, at each grant:
  - Data grant while if_req = 1: increment, saturating at STARVE_MAX.
  - Any fetch grant: clear to 0.
  - Data grant with if_req = 0: unchanged.
- mem_ack received in IDLE is ignored.
- Requester inputs are sampled only in the accept cycle; later changes have no effect.

Test Plan:
- Single fetch, addr 0x10, memory acks 2 cycles after mem_req with 0x8C010004 -> if_gnt at cycle 0; mem_req/mem_addr=0x10/mem_we=0 for 3 cycles; if_rvalid=1 and if_rdata=0x8C010004 exactly one cycle after ack; d_rvalid stays 0.
- Store d_addr 0x40, d_wdata 0xDEADBEEF, zero-wait memory -> mem_we=1, mem_wdata=0xDEADBEEF for one cycle; d_rvalid=1 with d_rdata=0 and err=0 on the next cycle.
- if_req and d_req held high continuously, STARVE_MAX=4, zero-wait memory -> grant sequence D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each I grant.
- Misaligned load d_addr 0x43 -> d_gnt=1; mem_req never rises; next cycle d_rvalid=1, err=1, d_rdata=0; a fetch granted in that same cycle proceeds normally.
- rst driven low while in ISSUE with mem_ack withheld -> mem_req=0 asynchronously, no rvalid; after release, a new fetch to 0x0 completes with a single if_rvalid.
- Memory stalls 5 cycles on a load while if_req is asserted -> if_gnt stays 0 and mem_addr stays stable throughout; if_gnt=1 in the first IDLE cycle after the ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one word-wide memory port between instruction fetch and load/store.
// One transaction in flight; data has priority, with an anti-starvation limit for fetch.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [0:0] {StIdle = 1'b0, StIssue = 1'b1} state_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  state_e            r_state, w_state;
  logic [3:0]        r_starve_cnt, w_starve_cnt;
  logic              r_owner_d, w_owner_d;
  logic              r_we, w_we;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic              r_if_rvalid, w_if_rvalid;
  logic              r_d_rvalid, w_d_rvalid;
  logic              r_err, w_err;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata;
  logic [DATA_W-1:0] r_d_rdata, w_d_rdata;

  logic              w_idle;
  logic              w_starve_hit;
  logic              w_if_gnt;
  logic              w_d_gnt;
  logic [ADDR_W-1:0] w_acc_addr;
  logic              w_misaligned;

  // Grants are gated by rst so every output reads 0 while reset is held.
  assign w_idle       = (r_state == StIdle) & rst;
  assign w_starve_hit = (r_starve_cnt == StarveMax);
  assign w_d_gnt      = w_idle & d_req & ~(if_req & w_starve_hit);
  assign w_if_gnt     = w_idle & if_req & ~w_d_gnt;
  assign w_acc_addr   = w_d_gnt ? d_addr : if_addr;
  assign w_misaligned = |w_acc_addr[1:0];

  always_comb begin
    w_state      = r_state;
    w_starve_cnt = r_starve_cnt;
    w_owner_d    = r_owner_d;
    w_we         = r_we;
    w_addr       = r_addr;
    w_wdata      = r_wdata;
    w_if_rvalid  = 1'b0;
    w_d_rvalid   = 1'b0;
    w_err        = 1'b0;
    w_if_rdata   = '0;
    w_d_rdata    = '0;

    unique case (r_state)
      StIdle: begin
        if (w_if_gnt || w_d_gnt) begin
          w_owner_d = w_d_gnt;
          w_we      = w_d_gnt & d_we;
          w_addr    = {w_acc_addr[ADDR_W-1:2], 2'b00};
          w_wdata   = w_d_gnt ? d_wdata : '0;
          if (w_if_gnt) begin
            w_starve_cnt = '0;
          end else if (if_req && !w_starve_hit) begin
            w_starve_cnt = r_starve_cnt + 4'd1;
          end
          // Misaligned words are answered locally and never reach memory.
          if (w_misaligned) begin
            w_if_rvalid = w_if_gnt;
            w_d_rvalid  = w_d_gnt;
            w_err       = 1'b1;
          end else begin
            w_state = StIssue;
          end
        end
      end
      StIssue: begin
        if (mem_ack) begin
          w_state     = StIdle;
          w_if_rvalid = ~r_owner_d;
          w_d_rvalid  = r_owner_d;
          if (!r_we) begin
            if (r_owner_d) begin
              w_d_rdata = mem_rdata;
            end else begin
              w_if_rdata = mem_rdata;
            end
          end
        end
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_starve_cnt <= '0;
      r_owner_d    <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_if_rvalid  <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_err        <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_state      <= w_state;
      r_starve_cnt <= w_starve_cnt;
      r_owner_d    <= w_owner_d;
      r_we         <= w_we;
      r_addr       <= w_addr;
      r_wdata      <= w_wdata;
      r_if_rvalid  <= w_if_rvalid;
      r_d_rvalid   <= w_d_rvalid;
      r_err        <= w_err;
      r_if_rdata   <= w_if_rdata;
      r_d_rdata    <= w_d_rdata;
    end
  end

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign err       = r_err;
  assign mem_req   = (r_state == StIssue);
  assign busy      = (r_state == StIssue);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int unsigned STARVE_MAX = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  mem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .err      (err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory device (responder) and the model's own view of memory contents.
  logic [31:0] mem_arr [64];
  logic [31:0] ref_mem [64];
  bit  mem_active;
  int  mem_wait;
  int  mem_lat;
  int  forced_lat;
  bit  spurious_en;
  bit  auto_req;
  bit  seen_if_gnt;
  bit  seen_d_gnt;

  // Transaction-level model state.
  bit          m_busy;
  bit          m_owner_d;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  int          m_starve;
  bit          m_rv;
  bit          m_rv_d;
  bit          m_rv_err;
  logic [31:0] m_rv_data;
  bit          log_en;
  byte         g_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    bit          e_i;
    bit          e_d;
    logic [31:0] a;
    int          idx;
    if (!rst) begin
      chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
      chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      m_busy      = 1'b0;
      m_starve    = 0;
      m_rv        = 1'b0;
      seen_if_gnt = 1'b0;
      seen_d_gnt  = 1'b0;
      return;
    end
    chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, m_rv && !m_rv_d});
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, m_rv && m_rv_d});
    chk("err", {31'd0, err}, {31'd0, m_rv && m_rv_err});
    if (m_rv && !m_rv_d) chk("if_rdata", if_rdata, m_rv_data);
    if (m_rv && m_rv_d) chk("d_rdata", d_rdata, m_rv_data);

    e_d = !m_busy && d_req && !(if_req && m_starve == STARVE_MAX);
    e_i = !m_busy && if_req && !e_d;
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, e_i});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, e_d});
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_busy});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    if (m_busy) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end

    m_rv = 1'b0;
    if (m_busy) begin
      if (mem_ack) begin
        idx       = int'(m_addr[7:2]);
        m_rv      = 1'b1;
        m_rv_d    = m_owner_d;
        m_rv_err  = 1'b0;
        m_rv_data = m_we ? 32'd0 : ref_mem[idx];
        if (m_we) ref_mem[idx] = m_wdata;
        m_busy = 1'b0;
      end
    end else if (e_i || e_d) begin
      a         = e_d ? d_addr : if_addr;
      m_owner_d = e_d;
      m_we      = e_d && d_we;
      m_wdata   = d_wdata;
      m_addr    = a;
      if (log_en) g_log.push_back(e_d ? 8'h44 : 8'h49);
      if (e_i) m_starve = 0;
      else if (if_req && m_starve < STARVE_MAX) m_starve++;
      if (a[1:0] != 2'b00) begin
        m_rv      = 1'b1;
        m_rv_d    = e_d;
        m_rv_err  = 1'b1;
        m_rv_data = 32'd0;
      end else begin
        m_busy = 1'b1;
      end
    end
    seen_if_gnt = if_gnt;
    seen_d_gnt  = d_gnt;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check_cycle();
    end
  end

  task automatic mem_step();
    int idx;
    if (!rst) begin
      mem_active = 1'b0;
      mem_ack    = 1'b0;
      return;
    end
    if (mem_req) begin
      if (!mem_active) begin
        mem_active = 1'b1;
        mem_wait   = 0;
        mem_lat    = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 3));
      end
      if (mem_wait == mem_lat) begin
        idx       = int'(mem_addr[7:2]);
        mem_ack   = 1'b1;
        mem_rdata = mem_arr[idx];
        if (mem_we) mem_arr[idx] = mem_wdata;
      end else begin
        mem_ack = 1'b0;
      end
      mem_wait++;
    end else begin
      mem_active = 1'b0;
      mem_ack    = spurious_en && ($urandom_range(0, 7) == 0);
      mem_rdata  = $urandom;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 63)) << 2;
    if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic req_step();
    if (if_req && seen_if_gnt) if_req = 1'b0;
    if (!if_req) begin
      if_addr = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = rand_addr();
      end
    end
    if (d_req && seen_d_gnt) d_req = 1'b0;
    if (!d_req) begin
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_we    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        d_req  = 1'b1;
        d_addr = rand_addr();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_step();
    if (auto_req) req_step();
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    mem_arr[idx] = v;
    ref_mem[idx] = v;
  endtask

  task automatic wait_rv(input bit want_d, output bit found, output int req_cycles);
    found      = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      if (mem_req) req_cycles++;
      if (want_d ? d_rvalid : if_rvalid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  bit          found;
  int          ncyc;
  int          pulses;
  logic [79:0] log_bits;

  initial begin
    rst         = 1'b0;
    if_req      = 1'b0;
    if_addr     = '0;
    d_req       = 1'b0;
    d_we        = 1'b0;
    d_addr      = '0;
    d_wdata     = '0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    forced_lat  = -1;
    spurious_en = 1'b0;
    auto_req    = 1'b0;
    log_en      = 1'b0;
    for (int i = 0; i < 64; i++) set_word(i, 32'hA5000000 ^ (32'(i) * 32'h01010101));
    #1;
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Single fetch, memory acks on the third mem_req cycle.
    forced_lat = 2;
    set_word(4, 32'h8C010004);
    if_req  = 1'b1;
    if_addr = 32'h10;
    #1 chk("t1_if_gnt", {31'd0, if_gnt}, 32'd1);
    tick();
    if_req = 1'b0;
    wait_rv(1'b0, found, ncyc);
    chk("t1_found", {31'd0, found}, 32'd1);
    chk("t1_req_cycles", 32'(ncyc), 32'd3);
    chk("t1_if_rdata", if_rdata, 32'h8C010004);
    chk("t1_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    tick();

    // Store with zero-wait memory.
    forced_lat = 0;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h40;
    d_wdata = 32'hDEADBEEF;
    tick();
    d_req = 1'b0;
    chk("t2_mem_req", {31'd0, mem_req}, 32'd1);
    chk("t2_mem_we", {31'd0, mem_we}, 32'd1);
    chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("t2_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("t2_d_rdata", d_rdata, 32'd0);
    chk("t2_err", {31'd0, err}, 32'd0);
    chk("t2_mem_req_drop", {31'd0, mem_req}, 32'd0);
    tick();

    // Both requesters held high: fetch wins after STARVE_MAX data grants.
    g_log.delete();
    log_en  = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h20;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h80;
    for (int i = 0; i < 60 && g_log.size() < 10; i++) tick();
    if_req = 1'b0;
    d_req  = 1'b0;
    log_en = 1'b0;
    log_bits = '0;
    for (int i = 0; i < 10 && i < g_log.size(); i++) log_bits[79-8*i -: 8] = g_log[i];
    checks++;
    if (log_bits !== "DDDDIDDDDI") begin
      errors++;
      $display("FAIL t3_grant_seq: actual %s required DDDDIDDDDI", log_bits);
    end
    chk("t3_model_starve", 32'(m_starve), 32'd0);
    repeat (4) tick();

    // Misaligned load answered locally; fetch granted alongside its response.
    forced_lat = 1;
    set_word(2, 32'h12345678);
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h43;
    #1 chk("t4_d_gnt", {31'd0, d_gnt}, 32'd1);
    tick();
    d_req   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h8;
    #1;
    chk("t4_no_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t4_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_d_rdata", d_rdata, 32'd0);
    chk("t4_if_gnt", {31'd0, if_gnt}, 32'd1);
    tick();
    if_req = 1'b0;
    chk("t4_fetch_mem_req", {31'd0, mem_req}, 32'd1);
    wait_rv(1'b0, found, ncyc);
    chk("t4_found", {31'd0, found}, 32'd1);
    chk("t4_if_rdata", if_rdata, 32'h12345678);
    chk("t4_if_err", {31'd0, err}, 32'd0);
    repeat (2) tick();

    // Load stalled 5 cycles while fetch waits.
    forced_lat = 5;
    set_word(17, 32'hCAFEF00D);
    set_word(3, 32'h0BADC0DE);
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h44;
    tick();
    d_req   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0C;
    ncyc  = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (mem_req) begin
        chk("t5_if_gnt_stall", {31'd0, if_gnt}, 32'd0);
        chk("t5_mem_addr", mem_addr, 32'h44);
        ncyc++;
        if (ncyc == 6) forced_lat = 0;
        tick();
      end else begin
        chk("t5_if_gnt_after", {31'd0, if_gnt}, 32'd1);
        chk("t5_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("t5_d_rdata", d_rdata, 32'hCAFEF00D);
        found = 1'b1;
      end
    end
    chk("t5_stall_cycles", 32'(ncyc), 32'd6);
    tick();
    if_req = 1'b0;
    wait_rv(1'b0, found, ncyc);
    chk("t5_found", {31'd0, found}, 32'd1);
    chk("t5_if_rdata", if_rdata, 32'h0BADC0DE);
    repeat (2) tick();

    // Asynchronous reset while memory withholds ack.
    forced_lat = 1000;
    if_req  = 1'b1;
    if_addr = 32'h30;
    tick();
    if_req = 1'b0;
    repeat (2) tick();
    chk("t6_mem_req_before", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_mem_req_async", {31'd0, mem_req}, 32'd0);
    chk("t6_busy_async", {31'd0, busy}, 32'd0);
    repeat (2) tick();
    rst        = 1'b1;
    forced_lat = 0;
    set_word(0, 32'h00C0FFEE);
    pulses = 0;
    tick();
    if (if_rvalid) pulses++;
    if_req  = 1'b1;
    if_addr = 32'h0;
    tick();
    if_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (if_rvalid) begin
        pulses++;
        chk("t6_if_rdata", if_rdata, 32'h00C0FFEE);
      end
      tick();
    end
    chk("t6_pulses", 32'(pulses), 32'd1);

    // Randomized traffic with random latency and stray acks while idle.
    forced_lat  = -1;
    spurious_en = 1'b1;
    auto_req    = 1'b1;
    repeat (3000) tick();
    auto_req    = 1'b0;
    spurious_en = 1'b0;
    if_req      = 1'b0;
    d_req       = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
